// File: rtl/root_result_collector_pkg.sv
// Shared message layout, type codes and FSM states for root_result_collector.
// Every other root_result_collector file imports this package.
package root_result_collector_pkg;

    localparam int MSG_WIDTH     = 64;
    localparam int TYPE_LSB      = 60;
    localparam int TYPE_WIDTH    = 4;
    localparam int ID_LSB        = 0;
    localparam int ID_WIDTH      = 32;
    localparam int PAYLOAD_LSB   = 0;
    localparam int PAYLOAD_WIDTH = 32;

    typedef enum logic [TYPE_WIDTH-1:0] {
        MSG_HEADER = 4'h1,
        MSG_ROOT   = 4'h2,
        MSG_END    = 4'h3
    } msg_type_e;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_EMIT_ID,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [TYPE_WIDTH-1:0] msg_type(input logic [MSG_WIDTH-1:0] msg);
        return msg[TYPE_LSB +: TYPE_WIDTH];
    endfunction

endpackage

// File: rtl/root_result_collector_leaf_header_tracker.sv
// Per-leaf header-seen bits and test-ID latch for root_result_collector.
// ROOT_RESULT_COLLECTOR_ID_CHECK_EN keeps every leaf's ID and reports disagreement with leaf 0.
module leaf_header_tracker
    import root_result_collector_pkg::*;
#(
    parameter int NUM_LEAVES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LEAVES-1:0]          hdr_accept,
    input  logic [ID_WIDTH*NUM_LEAVES-1:0] hdr_ids,
    input  logic                           clear,
    output logic [NUM_LEAVES-1:0]          hdr_seen,
    output logic [ID_WIDTH-1:0]            leaf0_id_next
`ifdef ROOT_RESULT_COLLECTOR_ID_CHECK_EN
    ,
    output logic                           id_mismatch_next
`endif
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_seen <= '0;
        end else if (clear) begin
            hdr_seen <= '0;
        end else begin
            hdr_seen <= hdr_seen | hdr_accept;
        end
    end

`ifdef ROOT_RESULT_COLLECTOR_ID_CHECK_EN
    logic [NUM_LEAVES-1:0][ID_WIDTH-1:0] id_q;
    logic [NUM_LEAVES-1:0][ID_WIDTH-1:0] id_next;

    // The comparison looks at the IDs as they will be after this cycle's accepts,
    // so a mismatch is caught on the very cycle the last header arrives.
    always_comb begin
        id_next = id_q;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (hdr_accept[i]) begin
                id_next[i] = hdr_ids[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    always_comb begin
        id_mismatch_next = 1'b0;
        for (int i = 1; i < NUM_LEAVES; i++) begin
            if (id_next[i] != id_next[0]) begin
                id_mismatch_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_q <= '0;
        end else begin
            id_q <= id_next;
        end
    end

    assign leaf0_id_next = id_next[0];
`else
    logic [ID_WIDTH-1:0] leaf0_id_q;
    logic                unused_ids;

    assign unused_ids    = ^hdr_ids;
    assign leaf0_id_next = hdr_accept[0] ? hdr_ids[ID_WIDTH-1:0] : leaf0_id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leaf0_id_q <= '0;
        end else if (hdr_accept[0]) begin
            leaf0_id_q <= hdr_ids[ID_WIDTH-1:0];
        end
    end
`endif

endmodule

// File: rtl/root_result_collector.sv
// Collects a header from every leaf, emits leaf 0's test ID, then drains ROOT results leaf by leaf.
// Optional cross-leaf ID check: define ROOT_RESULT_COLLECTOR_ID_CHECK_EN.
module root_result_collector
    import root_result_collector_pkg::*;
#(
    parameter int NUM_LEAVES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MSG_WIDTH*NUM_LEAVES-1:0]  in_data,
    input  logic [NUM_LEAVES-1:0]            in_valid,
    output logic [NUM_LEAVES-1:0]            in_ready,
    output logic [PAYLOAD_WIDTH-1:0]         out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             id_error,
    output logic [CNT_WIDTH-1:0]             test_count
);

    localparam int               IDX_W     = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
    localparam logic [IDX_W-1:0] LAST_LEAF = IDX_W'(NUM_LEAVES - 1);

    state_e                         state;
    state_e                         state_next;
    logic [IDX_W-1:0]               leaf_idx;
    logic [NUM_LEAVES-1:0]          hdr_seen;
    logic [NUM_LEAVES-1:0]          hdr_accept;
    logic [ID_WIDTH*NUM_LEAVES-1:0] hdr_ids;
    logic [ID_WIDTH-1:0]            leaf0_id_next;
    logic [MSG_WIDTH-1:0]           cur_msg;
    logic                           collect_bad;
    logic                           drain_ready;
    logic                           all_seen;
    logic                           load_id;
    logic                           load_root;
    logic                           leaf_adv;
    logic                           hdr_clear;
    logic                           count_inc;
    logic                           set_err;
`ifdef ROOT_RESULT_COLLECTOR_ID_CHECK_EN
    logic                           id_mismatch_next;
`endif

    assign cur_msg  = in_data[leaf_idx*MSG_WIDTH +: MSG_WIDTH];
    assign busy     = (state != ST_COLLECT);
    assign all_seen = &(hdr_seen | hdr_accept);

    leaf_header_tracker #(
        .NUM_LEAVES (NUM_LEAVES)
    ) u_tracker (
        .clk              (clk),
        .reset            (reset),
        .hdr_accept       (hdr_accept),
        .hdr_ids          (hdr_ids),
        .clear            (hdr_clear),
        .hdr_seen         (hdr_seen),
        .leaf0_id_next    (leaf0_id_next)
`ifdef ROOT_RESULT_COLLECTOR_ID_CHECK_EN
        ,
        .id_mismatch_next (id_mismatch_next)
`endif
    );

    // Header acceptance is kept apart from the FSM so the tracker's look-ahead
    // outputs never feed back into the block that produces hdr_accept.
    always_comb begin
        hdr_accept  = '0;
        hdr_ids     = '0;
        collect_bad = 1'b0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            hdr_ids[i*ID_WIDTH +: ID_WIDTH] = in_data[i*MSG_WIDTH + ID_LSB +: ID_WIDTH];
            if (state == ST_COLLECT && in_valid[i] && !hdr_seen[i]) begin
                if (msg_type(in_data[i*MSG_WIDTH +: MSG_WIDTH]) == MSG_HEADER) begin
                    hdr_accept[i] = 1'b1;
                end else begin
                    collect_bad = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = '0;
        drain_ready = !out_valid || out_ready;
        load_id     = 1'b0;
        load_root   = 1'b0;
        leaf_adv    = 1'b0;
        hdr_clear   = 1'b0;
        count_inc   = 1'b0;
        set_err     = 1'b0;
        case (state)
            ST_COLLECT: begin
                in_ready = ~hdr_seen;
                set_err  = collect_bad;
                if (all_seen) begin
                    state_next = ST_EMIT_ID;
                    load_id    = 1'b1;
`ifdef ROOT_RESULT_COLLECTOR_ID_CHECK_EN
                    if (id_mismatch_next) begin
                        set_err = 1'b1;
                    end
`endif
                end
            end
            ST_EMIT_ID: begin
                if (out_valid && out_ready) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                in_ready[leaf_idx] = drain_ready;
                if (in_valid[leaf_idx] && drain_ready) begin
                    case (msg_type(cur_msg))
                        MSG_ROOT: load_root = 1'b1;
                        MSG_END: begin
                            leaf_adv = 1'b1;
                            if (leaf_idx == LAST_LEAF) begin
                                state_next = ST_DONE;
                            end
                        end
                        default: set_err = 1'b1;
                    endcase
                end
            end
            ST_DONE: begin
                if (!out_valid) begin
                    state_next = ST_COLLECT;
                    hdr_clear  = 1'b1;
                    count_inc  = 1'b1;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // The output register holds its word until consumed; a new load may replace
    // it in the same cycle it is consumed, giving one word per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_COLLECT;
            leaf_idx   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            id_error   <= 1'b0;
            test_count <= '0;
        end else begin
            state <= state_next;
            if (set_err) begin
                id_error <= 1'b1;
            end
            if (count_inc) begin
                test_count <= test_count + CNT_WIDTH'(1);
            end
            if (state == ST_EMIT_ID) begin
                leaf_idx <= '0;
            end else if (leaf_adv) begin
                leaf_idx <= leaf_idx + IDX_W'(1);
            end
            if (load_id) begin
                out_data  <= leaf0_id_next;
                out_valid <= 1'b1;
            end else if (load_root) begin
                out_data  <= cur_msg[PAYLOAD_LSB +: PAYLOAD_WIDTH];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_root_result_collector.sv
// Directed self-checking bench for root_result_collector (4 leaves, 16-bit counter).
// Expected id_error for mismatched IDs follows ROOT_RESULT_COLLECTOR_ID_CHECK_EN.
module tb_root_result_collector;

    localparam int NL = 4;
    localparam int CW = 16;
    localparam int TIMEOUT = 400;
`ifdef ROOT_RESULT_COLLECTOR_ID_CHECK_EN
    localparam logic EXP_MISMATCH_ERR = 1'b1;
`else
    localparam logic EXP_MISMATCH_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [64*NL-1:0] in_data;
    logic [NL-1:0]   in_valid;
    logic [NL-1:0]   in_ready;
    logic [31:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            id_error;
    logic [CW-1:0]   test_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] lq [NL][$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    root_result_collector #(
        .NUM_LEAVES (NL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .id_error   (id_error),
        .test_count (test_count)
    );

    function automatic logic [63:0] hdr(input logic [31:0] id);
        return {4'h1, 28'h0, id};
    endfunction

    function automatic logic [63:0] root(input logic [15:0] x, input logic [15:0] y);
        return {4'h2, 28'h0, x, y};
    endfunction

    function automatic logic [63:0] end_msg();
        return {4'h3, 60'h0};
    endfunction

    task automatic refresh();
        for (int i = 0; i < NL; i++) begin
            in_valid[i] = (lq[i].size() > 0);
            if (lq[i].size() > 0) in_data[i*64 +: 64] = lq[i][0];
            else                  in_data[i*64 +: 64] = 64'h0;
        end
    endtask

    // One clock: sample handshakes on the falling edge, advance leaf queues after the rising edge.
    task automatic step();
        logic [NL-1:0] fire;
        @(negedge clk);
        fire = in_valid & in_ready;
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (fire[i]) void'(lq[i].pop_front());
        end
        refresh();
    endtask

    task automatic run_to_count(input logic [CW-1:0] target, output int n);
        n = 0;
        while (test_count !== target && n < TIMEOUT) begin
            step();
            n++;
        end
    endtask

    task automatic load_body(input int i);
        lq[i].push_back(root(16'hA0 + 16'(i), 16'd1));
        lq[i].push_back(root(16'hA0 + 16'(i), 16'd2));
        lq[i].push_back(end_msg());
    endtask

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(32'h7);
        for (int i = 0; i < NL; i++) begin
            for (int k = 1; k <= 2; k++) exp_q.push_back({16'hA0 + 16'(i), 16'(k)});
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) lq[i].delete();
        refresh();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        got.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) lq[i].delete();
        refresh();
        @(negedge clk);
        checks++; if (in_ready !== 4'hF) begin errors++; $display("[TB] FAIL reset_in_ready: got %h expected f", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (id_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_error: got %b expected 0", id_error); end
        checks++; if (test_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_test_count: got %0d expected 0", test_count); end
        @(posedge clk);
        #1 reset = 1'b1;
        got.delete();
    endtask

    task automatic test_same_cycle();
        int n;
        got.delete();
        build_exp();
        for (int i = 0; i < NL; i++) begin
            lq[i].push_back(hdr(32'h7));
            load_body(i);
        end
        refresh();
        step();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h7)
            begin errors++; $display("[TB] FAIL same_emit_id: busy=%b valid=%b data=%h expected 1 1 00000007", busy, out_valid, out_data); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL same_emit_ready: got %h expected 0", in_ready); end
        run_to_count(16'd1, n);
        checks++; if (n != 14) begin errors++; $display("[TB] FAIL same_cycles: got %0d expected 14", n); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL same_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL same_word%0d: got %h expected %h", k, got[k], exp_q[k]); end
        end
        checks++; if (id_error !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL same_end: id_error=%b busy=%b expected 0 0", id_error, busy); end
    endtask

    task automatic test_staggered();
        int n;
        got.delete();
        build_exp();
        for (int i = NL - 1; i >= 1; i--) begin
            lq[i].push_back(hdr(32'h7));
            load_body(i);
            refresh();
            step();
        end
        checks++; if (in_ready !== 4'b0001 || busy !== 1'b0)
            begin errors++; $display("[TB] FAIL stag_wait: in_ready=%h busy=%b expected 1 0", in_ready, busy); end
        lq[0].push_back(hdr(32'h7));
        load_body(0);
        refresh();
        step();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h7)
            begin errors++; $display("[TB] FAIL stag_emit: busy=%b valid=%b data=%h expected 1 1 00000007", busy, out_valid, out_data); end
        run_to_count(16'd2, n);
        checks++; if (n >= TIMEOUT) begin errors++; $display("[TB] FAIL stag_timeout: test_count=%0d expected 2", test_count); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL stag_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL stag_word%0d: got %h expected %h", k, got[k], exp_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        got.delete();
        build_exp();
        for (int i = 0; i < NL; i++) begin
            lq[i].push_back(hdr(32'h7));
            load_body(i);
        end
        refresh();
        n = 0;
        while (got.size() < 2 && n < 50) begin step(); n++; end
        checks++; if (n >= 50) begin errors++; $display("[TB] FAIL bp_start: got %0d words expected 2", got.size()); end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[2] || in_ready !== 4'h0)
                begin errors++; $display("[TB] FAIL bp_hold%0d: valid=%b data=%h ready=%h expected 1 %h 0", k, out_valid, out_data, in_ready, exp_q[2]); end
        end
        out_ready = 1'b1;
        run_to_count(16'd3, n);
        checks++; if (n >= TIMEOUT) begin errors++; $display("[TB] FAIL bp_timeout: test_count=%0d expected 3", test_count); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL bp_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL bp_word%0d: got %h expected %h", k, got[k], exp_q[k]); end
        end
    endtask

    task automatic test_id_mismatch();
        int n;
        got.delete();
        build_exp();
        for (int i = 0; i < NL; i++) begin
            lq[i].push_back(hdr((i == 2) ? 32'h8 : 32'h7));
            load_body(i);
        end
        refresh();
        step();
        checks++; if (out_data !== 32'h7 || id_error !== EXP_MISMATCH_ERR)
            begin errors++; $display("[TB] FAIL mism_emit: data=%h id_error=%b expected 00000007 %b", out_data, id_error, EXP_MISMATCH_ERR); end
        run_to_count(16'd4, n);
        checks++; if (n >= TIMEOUT) begin errors++; $display("[TB] FAIL mism_timeout: test_count=%0d expected 4", test_count); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL mism_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL mism_word%0d: got %h expected %h", k, got[k], exp_q[k]); end
        end
        checks++; if (id_error !== EXP_MISMATCH_ERR) begin errors++; $display("[TB] FAIL mism_sticky: got %b expected %b", id_error, EXP_MISMATCH_ERR); end
    endtask

    task automatic test_bad_type();
        int n;
        do_reset();
        checks++; if (id_error !== 1'b0 || test_count !== 16'd0)
            begin errors++; $display("[TB] FAIL bad_pre: id_error=%b count=%0d expected 0 0", id_error, test_count); end
        lq[1].push_back(root(16'h1, 16'h1));
        refresh();
        step();
        checks++; if (id_error !== 1'b1 || in_ready !== 4'hF || busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL bad_root_collect: id_error=%b ready=%h busy=%b valid=%b expected 1 f 0 0", id_error, in_ready, busy, out_valid); end
        do_reset();
        got.delete();
        build_exp();
        for (int i = 0; i < NL; i++) begin
            lq[i].push_back(hdr(32'h7));
            if (i == 0) lq[i].push_back({4'hF, 60'h0000_0000_DEAD_BEEF});
            if (i == 1) lq[i].push_back(hdr(32'h9));
            load_body(i);
        end
        refresh();
        run_to_count(16'd1, n);
        checks++; if (n >= TIMEOUT) begin errors++; $display("[TB] FAIL bad_timeout: test_count=%0d expected 1", test_count); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL bad_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL bad_word%0d: got %h expected %h", k, got[k], exp_q[k]); end
        end
        checks++; if (id_error !== 1'b1) begin errors++; $display("[TB] FAIL bad_drain_err: got %b expected 1", id_error); end
    endtask

    task automatic test_reset_mid_drain();
        int n;
        got.delete();
        for (int i = 0; i < NL; i++) begin
            lq[i].push_back(hdr(32'h7));
            load_body(i);
        end
        refresh();
        n = 0;
        while (got.size() < 2 && n < 50) begin step(); n++; end
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("[TB] FAIL mid_pre: valid=%b busy=%b expected 1 1", out_valid, busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0)
            begin errors++; $display("[TB] FAIL mid_async_out: valid=%b data=%h busy=%b expected 0 0 0", out_valid, out_data, busy); end
        checks++; if (in_ready !== 4'hF || test_count !== 16'd0 || id_error !== 1'b0)
            begin errors++; $display("[TB] FAIL mid_async_state: ready=%h count=%0d id_error=%b expected f 0 0", in_ready, test_count, id_error); end
        for (int i = 0; i < NL; i++) lq[i].delete();
        refresh();
        @(posedge clk);
        #1 reset = 1'b1;
        got.delete();
        build_exp();
        for (int i = 0; i < NL; i++) begin
            lq[i].push_back(hdr(32'h7));
            load_body(i);
        end
        refresh();
        run_to_count(16'd1, n);
        checks++; if (n >= TIMEOUT) begin errors++; $display("[TB] FAIL mid_timeout: test_count=%0d expected 1", test_count); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL mid_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL mid_word%0d: got %h expected %h", k, got[k], exp_q[k]); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        #2;
        $display("[TB] starting root_result_collector directed tests");
        test_reset();
        test_same_cycle();
        test_staggered();
        test_backpressure();
        test_id_mismatch();
        test_bad_type();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
